axi_lite_regbank_rd: RTL

- Parametrised AXI4-Lite slave register bank; next generation of the rd_interface fixed 4-register slave.
- Sits behind the PS AXI GP interconnect and exposes NUM_REGS control/status words to readout logic.
- Adds features the fixed slave lacks:
  - WSTRB byte enables.
  - Independent AW/W acceptance.
  - Read-only status registers fed from fabric.
  - Per-register write pulses.
  - SLVERR on decode/permission errors.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_wstrb_merge.sv | 21 ++
 rtl/axi_lite_regbank_rd.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and register-bank FSM state encodings.
// Latency: n/a (package only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/axi_lite_wstrb_merge.sv
// Byte-lane merge of a new write word into the old register value under WSTRB.
// Latency: combinational.
// Backpressure: none.
module axi_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  // Take each byte from the new word only where its strobe is set.
  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < DATA_WIDTH/8; k++) begin
      if (strb_i[k]) merged_o[k*8 +: 8] = new_i[k*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regbank_rd.sv
// AXI4-Lite slave exposing NUM_REGS words; RO words mirror reg_in, writes pulse wr_pulse.
// Latency: B one cycle after the last of AW/W handshakes; R one cycle after AR handshake.
// Backpressure: B and R held until accepted; no new AW/W/AR accepted while a response is pending.
module axi_lite_regbank_rd
  import axi_lite_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDXW  = ADDR_WIDTH - 2;
  localparam int STRBW = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi_lite_regbank_rd: DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 2 || NUM_REGS > 64) begin : g_bad_num_regs
    $error("axi_lite_regbank_rd: NUM_REGS must be 2..64");
  end
  if ((1 << IDXW) < NUM_REGS) begin : g_bad_addr_width
    $error("axi_lite_regbank_rd: ADDR_WIDTH too small for NUM_REGS");
  end

  wr_state_e wstate_q, wstate_d;
  rd_state_e rstate_q, rstate_d;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRBW-1:0]      wstrb_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_new, rd_word;
  logic [STRBW-1:0]      wr_strb;
  logic [IDXW-1:0]       wr_idx, rd_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_ok;
  logic [1:0]            rd_resp;

  // Write FSM: channel readies from state, gated off while in reset; next state on handshakes.
  always_comb begin
    wstate_d        = wstate_q;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (wstate_q)
      W_IDLE:    begin s00_axi_awready = 1'b1; s00_axi_wready = 1'b1; end
      W_HAVE_AW: s00_axi_wready  = 1'b1;
      W_HAVE_W:  s00_axi_awready = 1'b1;
      W_RESP:    s00_axi_bvalid  = 1'b1;
      default:   ;
    endcase
    if (s00_axi_areset) begin
      s00_axi_awready = 1'b0;
      s00_axi_wready  = 1'b0;
      s00_axi_bvalid  = 1'b0;
    end
    aw_hs = s00_axi_awvalid && s00_axi_awready;
    w_hs  = s00_axi_wvalid  && s00_axi_wready;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_AW;
        else if (w_hs)     wstate_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wstate_d = W_RESP;
      W_HAVE_W:  if (aw_hs) wstate_d = W_RESP;
      W_RESP:    if (s00_axi_bready) wstate_d = W_IDLE;
      default:   wstate_d = W_IDLE;
    endcase
    commit = (wstate_q != W_RESP) && (wstate_d == W_RESP);
  end

  // Write decode: the half arriving this cycle bypasses its holding register.
  always_comb begin
    wr_addr = aw_hs ? s00_axi_awaddr : awaddr_q;
    wr_data = w_hs  ? s00_axi_wdata  : wdata_q;
    wr_strb = w_hs  ? s00_axi_wstrb  : wstrb_q;
    wr_idx  = wr_addr[ADDR_WIDTH-1:2];
    wr_sel  = '0;
    wr_old  = '0;
    wr_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDXW'(i)) begin
        wr_old    = regs_q[i];
        wr_ok     = !RO_MASK[i];
        wr_sel[i] = !RO_MASK[i];
      end
    end
  end

  axi_lite_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (wr_old),
    .new_i    (wr_data),
    .strb_i   (wr_strb),
    .merged_o (wr_new)
  );

  // Write state register.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) wstate_q <= W_IDLE;
    else                wstate_q <= wstate_d;
  end

  // Write datapath: hold AW/W halves, update the register array and strobe on commit.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      bresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) awaddr_q <= s00_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (commit) begin
        bresp_q    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_pulse_q <= wr_sel;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_sel[i]) regs_q[i] <= wr_new;
        end
      end
    end
  end

  // Read FSM: accept AR only when no read response is outstanding.
  always_comb begin
    rstate_d        = rstate_q;
    s00_axi_arready = (rstate_q == R_IDLE) && !s00_axi_areset;
    s00_axi_rvalid  = (rstate_q == R_RESP) && !s00_axi_areset;
    ar_hs           = s00_axi_arvalid && s00_axi_arready;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_RESP;
      R_RESP:  if (s00_axi_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read decode: RO words come straight from reg_in, out-of-range reads as zero with SLVERR.
  always_comb begin
    rd_idx  = s00_axi_araddr[ADDR_WIDTH-1:2];
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) begin
        rd_word = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        rd_resp = RESP_OKAY;
      end
    end
  end

  // Read state and response registers; data sampled at the AR handshake.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
      RO_MASK[g] ? reg_in[g*DATA_WIDTH +: DATA_WIDTH] : regs_q[g];
  end

  assign s00_axi_bresp = bresp_q;
  assign s00_axi_rdata = rdata_q;
  assign s00_axi_rresp = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0], s00_axi_araddr[1:0]};

endmodule
